sgpio_stream_rx: RTL and testbench

Status-CPLD receiver for the SGPIO link driven by the baseboard CPLD on SGPIO_CK/SGPIO_LD/SGPIO_DATA. It synchronises the three lines into SYSCLK and deserialises one frame of drive-activity bits per SGPIO_LD period. It presents a stable, frame-atomic ACT_LED vector to the status LED logic, along with link-health and error indications.

---
 rtl/sgpio_pkg.sv | 18 +
 rtl/sgpio_sync.sv | 42 ++++
 rtl/sgpio_stream_rx.sv | 157 +++++++++++++++
 tb/tb_sgpio_stream_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgpio_pkg.sv
// Shared SGPIO definitions: receiver FSM encoding, frame width default, error-counter width.
package sgpio_pkg;

   // Also used by the baseboard transmitter, so both ends agree on frame length.
   localparam int unsigned NUM_BITS_DEF = 36;
   localparam int unsigned ERR_CNT_W    = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_WAIT_LD = 2'd2
   } sgpio_state_e;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
   endfunction

endpackage

// File: rtl/sgpio_sync.sv
// SGPIO input synchroniser with CK rising-edge detect; LD and DATA are delayed
// to stay aligned with the detected CK edge.
module sgpio_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_ck,
   input  logic i_ld,
   input  logic i_data,
   output logic o_ck_rise,
   output logic o_ld_s,
   output logic o_data_s
);

   logic [SYNC_STAGES-1:0] r_ck_sync;
   logic [SYNC_STAGES-1:0] r_ld_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic                   r_ck_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ck_sync   <= '0;
         r_ld_sync   <= '0;
         r_data_sync <= '0;
         r_ck_prev   <= 1'b0;
         o_ck_rise   <= 1'b0;
         o_ld_s      <= 1'b0;
         o_data_s    <= 1'b0;
      end else begin
         r_ck_sync   <= {r_ck_sync[SYNC_STAGES-2:0], i_ck};
         r_ld_sync   <= {r_ld_sync[SYNC_STAGES-2:0], i_ld};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_data};
         r_ck_prev   <= r_ck_sync[SYNC_STAGES-1];
         // All three outputs come from the same stage, so LD/DATA match the CK edge.
         o_ck_rise   <= r_ck_sync[SYNC_STAGES-1] & ~r_ck_prev;
         o_ld_s      <= r_ld_sync[SYNC_STAGES-1];
         o_data_s    <= r_data_sync[SYNC_STAGES-1];
      end
   end

endmodule

// File: rtl/sgpio_stream_rx.sv
// SGPIO frame receiver: deserialises one ACT_LED frame per SGPIO_LD period with
// framing-error and link-timeout handling. Optional macro: SGPIO_DOUBLE_FRAME_EN.
module sgpio_stream_rx
   import sgpio_pkg::*;
#(
   parameter int unsigned NUM_BITS    = NUM_BITS_DEF,
   parameter int unsigned TIMEOUT_CYC = 50000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 SYSCLK,
   input  logic                 RESET_N,
   input  logic                 SGPIO_CK,
   input  logic                 SGPIO_LD,
   input  logic                 SGPIO_DATA,
   output logic [NUM_BITS-1:0]  ACT_LED,
   output logic                 FRAME_VALID,
   output logic                 FRAME_ERR,
   output logic                 LINK_OK,
   output logic [ERR_CNT_W-1:0] ERR_CNT
);

   localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

   logic                w_ck_rise;
   logic                w_ld;
   logic                w_data;
   logic                w_to_hit;
   logic [NUM_BITS-1:0] w_first;
   logic [NUM_BITS-1:0] w_next;

   sgpio_state_e        r_state;
   logic [NUM_BITS-1:0] r_shift;
   logic [CNT_W-1:0]    r_cnt;
   logic [TO_W-1:0]     r_to_cnt;
`ifdef SGPIO_DOUBLE_FRAME_EN
   logic [NUM_BITS-1:0] r_cand;
   logic                r_cand_vld;
`endif

   sgpio_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk     (SYSCLK),
      .i_rst_n   (RESET_N),
      .i_ck      (SGPIO_CK),
      .i_ld      (SGPIO_LD),
      .i_data    (SGPIO_DATA),
      .o_ck_rise (w_ck_rise),
      .o_ld_s    (w_ld),
      .o_data_s  (w_data)
   );

   // Right shift: after NUM_BITS captures the first bit sits in bit 0.
   assign w_first  = {w_data, {(NUM_BITS-1){1'b0}}};
   assign w_next   = {w_data, r_shift[NUM_BITS-1:1]};
   assign w_to_hit = ~w_ck_rise && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= ST_IDLE;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_to_cnt    <= '0;
         ACT_LED     <= '0;
         FRAME_VALID <= 1'b0;
         FRAME_ERR   <= 1'b0;
         LINK_OK     <= 1'b0;
         ERR_CNT     <= '0;
`ifdef SGPIO_DOUBLE_FRAME_EN
         r_cand      <= '0;
         r_cand_vld  <= 1'b0;
`endif
      end else begin
         FRAME_VALID <= 1'b0;
         FRAME_ERR   <= 1'b0;

         if (w_ck_rise)
            r_to_cnt <= '0;
         else if (r_to_cnt != TO_W'(TIMEOUT_CYC))
            r_to_cnt <= r_to_cnt + TO_W'(1);

         if (w_to_hit) begin
            // Link lost: blank the LEDs and wait for a fresh LD.
            LINK_OK <= 1'b0;
            ACT_LED <= '0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
`ifdef SGPIO_DOUBLE_FRAME_EN
            r_cand_vld <= 1'b0;
`endif
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_ck_rise && w_ld) begin
                     r_shift <= w_first;
                     r_cnt   <= CNT_W'(1);
                     r_state <= ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  if (r_cnt == CNT_W'(NUM_BITS)) begin
`ifdef SGPIO_DOUBLE_FRAME_EN
                     if (r_cand_vld && (r_cand == r_shift)) begin
                        ACT_LED     <= r_shift;
                        FRAME_VALID <= 1'b1;
                        LINK_OK     <= 1'b1;
                     end else begin
                        r_cand     <= r_shift;
                        r_cand_vld <= 1'b1;
                     end
`else
                     ACT_LED     <= r_shift;
                     FRAME_VALID <= 1'b1;
                     LINK_OK     <= 1'b1;
`endif
                     r_cnt   <= '0;
                     r_state <= ST_WAIT_LD;
                  end else if (w_ck_rise) begin
                     if (w_ld) begin
                        // Early LD: drop the partial frame, restart on this bit.
                        FRAME_ERR <= 1'b1;
                        ERR_CNT   <= sat_inc(ERR_CNT);
                        r_shift   <= w_first;
                        r_cnt     <= CNT_W'(1);
`ifdef SGPIO_DOUBLE_FRAME_EN
                        r_cand_vld <= 1'b0;
`endif
                     end else begin
                        r_shift <= w_next;
                        r_cnt   <= r_cnt + CNT_W'(1);
                     end
                  end
               end
               ST_WAIT_LD: begin
                  if (w_ck_rise) begin
                     if (w_ld) begin
                        r_shift <= w_first;
                        r_cnt   <= CNT_W'(1);
                        r_state <= ST_SHIFT;
                     end else begin
                        FRAME_ERR <= 1'b1;
                        ERR_CNT   <= sat_inc(ERR_CNT);
                        r_state   <= ST_IDLE;
`ifdef SGPIO_DOUBLE_FRAME_EN
                        r_cand_vld <= 1'b0;
`endif
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sgpio_stream_rx.sv
// Scoreboard bench for sgpio_stream_rx; honours SGPIO_DOUBLE_FRAME_EN in its model.
`timescale 1ns/1ps
module tb_sgpio_stream_rx;

   localparam int unsigned NB   = 36;
   localparam int unsigned TO   = 1000;
   localparam int unsigned SS   = 2;
   localparam int unsigned HALF = 4;

   logic          SYSCLK     = 1'b0;
   logic          RESET_N    = 1'b0;
   logic          SGPIO_CK   = 1'b0;
   logic          SGPIO_LD   = 1'b0;
   logic          SGPIO_DATA = 1'b0;
   logic [NB-1:0] ACT_LED;
   logic          FRAME_VALID;
   logic          FRAME_ERR;
   logic          LINK_OK;
   logic [7:0]    ERR_CNT;

   int n_tests   = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int n_valid   = 0;
   int last_rise = 0;

   logic [NB-1:0] exp_q[$];
   logic [7:0]    err_q[$];

   logic [NB-1:0] m_act      = '0;
   logic [7:0]    m_err      = '0;
   logic          m_link     = 1'b0;
   int            m_commits  = 0;
   logic [NB-1:0] m_cand     = '0;
   logic          m_cand_vld = 1'b0;

   logic [NB-1:0] prev_act = '0;
   logic [NB-1:0] mon_exp;
   logic [7:0]    mon_err;
   logic [NB-1:0] hold_act;
   int            hold_valid;

   sgpio_stream_rx #(
      .NUM_BITS    (NB),
      .TIMEOUT_CYC (TO),
      .SYNC_STAGES (SS)
   ) dut (
      .SYSCLK      (SYSCLK),
      .RESET_N     (RESET_N),
      .SGPIO_CK    (SGPIO_CK),
      .SGPIO_LD    (SGPIO_LD),
      .SGPIO_DATA  (SGPIO_DATA),
      .ACT_LED     (ACT_LED),
      .FRAME_VALID (FRAME_VALID),
      .FRAME_ERR   (FRAME_ERR),
      .LINK_OK     (LINK_OK),
      .ERR_CNT     (ERR_CNT)
   );

   always #5 SYSCLK = ~SYSCLK;
   always @(posedge SYSCLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge SYSCLK);
   endtask

   // Model of the commit rule; pushes the expected ACT_LED for the monitor.
   task automatic model_frame(input logic [NB-1:0] d);
`ifdef SGPIO_DOUBLE_FRAME_EN
      if (m_cand_vld && m_cand == d) begin
         exp_q.push_back(d); m_act = d; m_link = 1'b1; m_commits++;
      end else begin
         m_cand = d; m_cand_vld = 1'b1;
      end
`else
      exp_q.push_back(d); m_act = d; m_link = 1'b1; m_commits++;
`endif
   endtask

   task automatic model_err();
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      err_q.push_back(m_err);
      m_cand_vld = 1'b0;
   endtask

   task automatic send_bit(input logic ld, input logic d);
      SGPIO_CK = 1'b0; SGPIO_LD = ld; SGPIO_DATA = d;
      clk_n(HALF);
      SGPIO_CK = 1'b1; last_rise = cyc;
      clk_n(HALF);
   endtask

   task automatic send_from(input logic [NB-1:0] d, input int start);
      for (int i = start; i < NB; i++) send_bit(i == 0, d[i]);
      SGPIO_CK = 1'b0; SGPIO_LD = 1'b0;
      clk_n(HALF);
   endtask

   task automatic send_frame(input logic [NB-1:0] d);
      model_frame(d);
      send_from(d, 0);
   endtask

   task automatic send_partial(input logic [NB-1:0] d, input int n);
      for (int i = 0; i < n; i++) send_bit(i == 0, d[i]);
   endtask

   task automatic do_reset();
      RESET_N = 1'b0; SGPIO_CK = 1'b0; SGPIO_LD = 1'b0; SGPIO_DATA = 1'b0;
      m_act = '0; m_err = '0; m_link = 1'b0; m_cand_vld = 1'b0;
      clk_n(3);
      RESET_N = 1'b1;
      clk_n(2);
   endtask

   // Monitor: commits, errors and partial-value detection, every cycle.
   always @(negedge SYSCLK) begin
      if (FRAME_VALID) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_commit: ACT_LED %h, none expected", ACT_LED);
         end else begin
            mon_exp = exp_q.pop_front();
            check("commit_data", 64'(ACT_LED), 64'(mon_exp));
            n_tests++;
            if ((cyc - last_rise) < int'(SS + 1) || (cyc - last_rise) > int'(SS + 4)) begin
               n_fail++;
               $display("FAIL commit_latency: %0d cycles after last CK rise, required %0d..%0d",
                        cyc - last_rise, SS + 1, SS + 4);
            end
         end
      end
      if (FRAME_ERR) begin
         if (err_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_err: ERR_CNT %h, no error expected", ERR_CNT);
         end else begin
            mon_err = err_q.pop_front();
            check("err_cnt_at_err", 64'(ERR_CNT), 64'(mon_err));
         end
      end
      if (ACT_LED !== prev_act) begin
         n_tests++;
         if (!(FRAME_VALID || ACT_LED == '0)) begin
            n_fail++;
            $display("FAIL act_led_partial: changed to %h without commit", ACT_LED);
         end
      end
      prev_act = ACT_LED;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clk_n(2);
      check("rst_act_led", 64'(ACT_LED), 64'h0);
      check("rst_frame_valid", 64'(FRAME_VALID), 64'h0);
      check("rst_frame_err", 64'(FRAME_ERR), 64'h0);
      check("rst_link_ok", 64'(LINK_OK), 64'h0);
      check("rst_err_cnt", 64'(ERR_CNT), 64'h0);
      do_reset();

      // Three clean frames.
      repeat (3) send_frame(36'hB_0000_0005);
      check("t1_act_led", 64'(ACT_LED), 64'(m_act));
      check("t1_valid_count", 64'(n_valid), 64'(m_commits));
      check("t1_link_ok", 64'(LINK_OK), 64'(m_link));
      check("t1_err_cnt", 64'(ERR_CNT), 64'h0);

      // All-ones then all-zeros.
      repeat (2) send_frame(36'hF_FFFF_FFFF);
      check("t2_ones", 64'(ACT_LED), 64'(m_act));
      repeat (2) send_frame(36'h0);
      check("t2_zeros", 64'(ACT_LED), 64'(m_act));

      // Early LD at bit 20, then a clean frame starting on that bit.
      send_frame(36'hA_5A5A_5A5A);
      hold_act = ACT_LED;
      send_partial(36'h1_2345_6789, 20);
      model_err();
      model_frame(36'hA_5A5A_5A5A);
      send_bit(1'b1, 1'b0);
      clk_n(8);
      check("t3_err_cnt", 64'(ERR_CNT), 64'h1);
      check("t3_act_hold", 64'(ACT_LED), 64'(hold_act));
      send_from(36'hA_5A5A_5A5A, 1);
      send_frame(36'hA_5A5A_5A5A);
      check("t3_act_led", 64'(ACT_LED), 64'(m_act));

      // Reset mid-frame clears outputs at once.
      send_partial(36'h3_C3C3_C3C3, 10);
      #2 RESET_N = 1'b0;
      #1;
      check("rst_mid_act_led", 64'(ACT_LED), 64'h0);
      check("rst_mid_link_ok", 64'(LINK_OK), 64'h0);
      check("rst_mid_err_cnt", 64'(ERR_CNT), 64'h0);
      do_reset();

      // Overlong frame: 37th bit with LD low.
      repeat (2) send_frame(36'h5_1234_0F0F);
      hold_act = ACT_LED;
      model_err();
      send_bit(1'b0, 1'b1);
      clk_n(8);
      check("t4_err_cnt", 64'(ERR_CNT), 64'h1);
      check("t4_act_hold", 64'(ACT_LED), 64'(hold_act));
      check("t4_state_idle", 64'(dut.r_state), 64'(sgpio_pkg::ST_IDLE));
      repeat (2) send_frame(36'h9_8765_4321);
      check("t4_recover", 64'(ACT_LED), 64'(m_act));
      check("t4_link_ok", 64'(LINK_OK), 64'h1);

      // CK stopped: link drops after TO cycles, recovers with the next frame.
      clk_n(900);
      check("t5_link_before_to", 64'(LINK_OK), 64'h1);
      clk_n(150);
      m_act = '0; m_link = 1'b0; m_cand_vld = 1'b0;
      check("t5_link_lost", 64'(LINK_OK), 64'h0);
      check("t5_act_cleared", 64'(ACT_LED), 64'h0);
      repeat (2) send_frame(36'h7_0000_0001);
      check("t5_link_back", 64'(LINK_OK), 64'h1);
      check("t5_act_led", 64'(ACT_LED), 64'(m_act));

`ifdef SGPIO_DOUBLE_FRAME_EN
      // X, Y, Y: only the second Y commits.
      hold_act = ACT_LED;
      hold_valid = n_valid;
      send_frame(36'h1_1111_1111);
      send_frame(36'h2_2222_2222);
      check("df_hold_act", 64'(ACT_LED), 64'(hold_act));
      check("df_hold_valid", 64'(n_valid), 64'(hold_valid));
      send_frame(36'h2_2222_2222);
      check("df_commit_act", 64'(ACT_LED), 64'h2_2222_2222);
      check("df_commit_valid", 64'(n_valid), 64'(hold_valid + 1));
`endif

      // 300 back-to-back early-LD errors saturate ERR_CNT.
      do_reset();
      for (int i = 0; i < 301; i++) begin
         if (i > 0) model_err();
         send_bit(1'b1, 1'b0);
      end
      SGPIO_CK = 1'b0; SGPIO_LD = 1'b0;
      clk_n(8);
      check("sat_err_cnt", 64'(ERR_CNT), 64'hFF);

      clk_n(20);
      check("pending_commits", 64'(exp_q.size()), 64'h0);
      check("pending_errs", 64'(err_q.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
